// File: rtl/array_11_access_ctrl.sv
// Single-port access controller for a 64x114 masked SRAM macro: merges write
// and read request channels onto RW0, zero-fills after reset, buffers reads.
module array_11_access_ctrl #(
  parameter int DEPTH         = 64,
  parameter int ADDR_W        = 6,
  parameter int DATA_W        = 114,
  parameter int MASK_W        = 2,
  parameter int STARVE_LIMIT  = 4,
  parameter int INIT_ON_RESET = 1
) (
  input  logic              clock,
  input  logic              reset_n,
  output logic              init_done,
  input  logic              w_valid,
  output logic              w_ready,
  input  logic [ADDR_W-1:0] w_addr,
  input  logic [MASK_W-1:0] w_mask,
  input  logic [DATA_W-1:0] w_data,
  input  logic              r_req_valid,
  output logic              r_req_ready,
  input  logic [ADDR_W-1:0] r_addr,
  output logic              r_resp_valid,
  input  logic              r_resp_ready,
  output logic [DATA_W-1:0] r_resp_data,
  output logic              sram_en,
  output logic              sram_wmode,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [MASK_W-1:0] sram_wmask,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);

  typedef enum logic {ST_INIT, ST_RUN} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] init_cnt_q, init_cnt_d;
  logic [SW-1:0]     starve_cnt_q, starve_cnt_d;
  logic              inflight_q, inflight_d;
  logic              wr_ptr_q, wr_ptr_d;
  logic              rd_ptr_q, rd_ptr_d;
  logic [1:0]        count_q, count_d;
  logic [DATA_W-1:0] fifo_q [2];

  logic       run, pop, push, can_read, starved, rd_gnt, wr_gnt;
  logic [2:0] credit_use;

  // Arbitration: a read wins unless a waiting write has lost STARVE_LIMIT times.
  always_comb begin
    run        = reset_n && (state_q == ST_RUN);
    pop        = r_resp_valid & r_resp_ready;
    push       = inflight_q;
    credit_use = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
    can_read   = (credit_use < 3'd2);
    starved    = w_valid && (starve_cnt_q == SW'(STARVE_LIMIT));
    rd_gnt     = run & r_req_valid & can_read & ~starved;
    wr_gnt     = run & w_valid & ~rd_gnt;
  end

  // Next-state logic.
  always_comb begin
    // NOTE: every comb output gets a default first, so no path can infer a latch.
    state_d      = state_q;
    init_cnt_d   = init_cnt_q;
    starve_cnt_d = starve_cnt_q;
    inflight_d   = rd_gnt;
    wr_ptr_d     = wr_ptr_q ^ push;
    rd_ptr_d     = rd_ptr_q ^ pop;
    count_d      = count_q + {1'b0, push} - {1'b0, pop};
    if (state_q == ST_INIT) begin
      init_cnt_d = init_cnt_q + 1'b1;
      if (init_cnt_q == ADDR_W'(DEPTH - 1)) begin
        state_d    = ST_RUN;
        init_cnt_d = '0;
      end
    end
    if (wr_gnt) begin
      starve_cnt_d = '0;
    end else if (rd_gnt && w_valid && (starve_cnt_q != SW'(STARVE_LIMIT))) begin
      starve_cnt_d = starve_cnt_q + 1'b1;
    end
  end

  // Outputs; the macro port is forced idle while reset_n is low.
  always_comb begin
    sram_en      = 1'b0;
    sram_wmode   = 1'b0;
    sram_addr    = '0;
    sram_wmask   = '0;
    sram_wdata   = '0;
    init_done    = run;
    r_req_ready  = rd_gnt;
    w_ready      = wr_gnt;
    r_resp_valid = (count_q != 2'd0);
    r_resp_data  = fifo_q[rd_ptr_q];
    if (reset_n) begin
      if (state_q == ST_INIT) begin
        sram_en    = 1'b1;
        sram_wmode = 1'b1;
        sram_addr  = init_cnt_q;
        sram_wmask = '1;
      end else if (rd_gnt) begin
        sram_en   = 1'b1;
        sram_addr = r_addr;
      end else if (wr_gnt) begin
        sram_en    = 1'b1;
        sram_wmode = 1'b1;
        sram_addr  = w_addr;
        sram_wmask = w_mask;
        sram_wdata = w_data;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= (INIT_ON_RESET != 0) ? ST_INIT : ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (!reset_n) begin
      init_cnt_q   <= '0;
      starve_cnt_q <= '0;
      inflight_q   <= 1'b0;
      wr_ptr_q     <= 1'b0;
      rd_ptr_q     <= 1'b0;
      count_q      <= 2'd0;
    end else begin
      init_cnt_q   <= init_cnt_d;
      starve_cnt_q <= starve_cnt_d;
      inflight_q   <= inflight_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
    end
  end

  // NOTE: FIFO storage is not reset; count_q alone decides which entries are valid.
  always_ff @(posedge clock) begin
    if (push) begin
      fifo_q[wr_ptr_q] <= sram_rdata;
    end
  end

endmodule

// File: tb/tb_array_11_access_ctrl.sv
// Directed bench for array_11_access_ctrl with a behavioural 64x114 masked
// SRAM macro model (1-cycle registered read) on the RW0 port.
module tb_array_11_access_ctrl;

  localparam int DEPTH  = 64;
  localparam int ADDR_W = 6;
  localparam int DATA_W = 114;
  localparam int MASK_W = 2;
  localparam int LANE_W = DATA_W / MASK_W;

  logic              clock = 1'b0;
  logic              reset_n = 1'b0;
  logic              init_done;
  logic              w_valid = 1'b0;
  logic              w_ready;
  logic [ADDR_W-1:0] w_addr = '0;
  logic [MASK_W-1:0] w_mask = '0;
  logic [DATA_W-1:0] w_data = '0;
  logic              r_req_valid = 1'b0;
  logic              r_req_ready;
  logic [ADDR_W-1:0] r_addr = '0;
  logic              r_resp_valid;
  logic              r_resp_ready = 1'b0;
  logic [DATA_W-1:0] r_resp_data;
  logic              sram_en;
  logic              sram_wmode;
  logic [ADDR_W-1:0] sram_addr;
  logic [MASK_W-1:0] sram_wmask;
  logic [DATA_W-1:0] sram_wdata;
  logic [DATA_W-1:0] sram_rdata = '0;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] dat [1:4];
  logic [DATA_W-1:0] lane0_ones;
  int checks = 0;
  int failures = 0;

  array_11_access_ctrl dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .init_done    (init_done),
    .w_valid      (w_valid),
    .w_ready      (w_ready),
    .w_addr       (w_addr),
    .w_mask       (w_mask),
    .w_data       (w_data),
    .r_req_valid  (r_req_valid),
    .r_req_ready  (r_req_ready),
    .r_addr       (r_addr),
    .r_resp_valid (r_resp_valid),
    .r_resp_ready (r_resp_ready),
    .r_resp_data  (r_resp_data),
    .sram_en      (sram_en),
    .sram_wmode   (sram_wmode),
    .sram_addr    (sram_addr),
    .sram_wmask   (sram_wmask),
    .sram_wdata   (sram_wdata),
    .sram_rdata   (sram_rdata)
  );

  always #5 clock = ~clock;

  // Macro model: masked write, registered read.
  always @(posedge clock) begin
    if (sram_en) begin
      if (sram_wmode) begin
        if (sram_wmask[0]) mem[sram_addr][LANE_W-1:0] <= sram_wdata[LANE_W-1:0];
        if (sram_wmask[1]) mem[sram_addr][DATA_W-1:LANE_W] <= sram_wdata[DATA_W-1:LANE_W];
      end else begin
        sram_rdata <= mem[sram_addr];
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_idle();
    w_valid      = 1'b0;
    r_req_valid  = 1'b0;
    r_resp_ready = 1'b0;
  endtask

  task automatic check_reset_outs(input string tag);
    chk({tag, "_ctl"}, {init_done, w_ready, r_req_ready, r_resp_valid, sram_en, sram_wmode}, 6'b0);
    chk({tag, "_addr"}, sram_addr, 0);
    chk({tag, "_wmask"}, sram_wmask, 0);
    chk({tag, "_wdata"}, sram_wdata, 0);
  endtask

  // Releases reset on the first cycle, then checks n zero-fill cycles.
  task automatic init_run(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      if (i == 0) reset_n = 1'b1;
      #1;
      chk("init_en_wmode", {sram_en, sram_wmode}, 2'b11);
      chk("init_addr", sram_addr, i);
      chk("init_wmask", sram_wmask, 2'b11);
      chk("init_wdata", sram_wdata, 0);
      chk("init_quiet", {w_ready, r_req_ready, init_done, r_resp_valid}, 4'b0);
    end
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = '1;
    dat[1] = 114'h0AA55;
    dat[2] = '1;
    dat[3] = 114'h123456789ABCDEF0123456789;
    dat[4] = 114'h5A5A5A5A5A5A;
    lane0_ones = '0;
    lane0_ones[LANE_W-1:0] = '1;

    // Reset state
    @(negedge clock);
    #1;
    check_reset_outs("rst0");
    @(negedge clock);

    // Zero-fill with both request channels held valid: nothing granted.
    w_valid = 1'b1;
    r_req_valid = 1'b1;
    init_run(DEPTH);
    @(negedge clock);
    set_idle();
    #1;
    chk("init_done", init_done, 1'b1);
    chk("run_idle_en", sram_en, 1'b0);

    // Reads of addr 0 and 63 return the zero fill.
    @(negedge clock);
    r_req_valid = 1'b1; r_addr = 6'd0;
    #1;
    chk("rd0_ready", r_req_ready, 1'b1);
    chk("rd0_port", {sram_en, sram_wmode, sram_wmask}, 4'b1000);
    chk("rd0_addr", sram_addr, 0);
    @(negedge clock);
    r_addr = 6'd63;
    #1;
    chk("rd63_ready", r_req_ready, 1'b1);
    chk("rd0_lat1", r_resp_valid, 1'b0);
    @(negedge clock);
    r_req_valid = 1'b0; r_resp_ready = 1'b1;
    #1;
    chk("rd0_valid", r_resp_valid, 1'b1);
    chk("rd0_data", r_resp_data, 0);
    @(negedge clock);
    #1;
    chk("rd63_valid", r_resp_valid, 1'b1);
    chk("rd63_data", r_resp_data, 0);
    @(negedge clock);
    r_resp_ready = 1'b0;
    #1;
    chk("rd_drained", r_resp_valid, 1'b0);

    // Masked write of lane 0, then read back with 2-cycle latency.
    @(negedge clock);
    w_valid = 1'b1; w_addr = 6'd5; w_mask = 2'b01; w_data = '1;
    #1;
    chk("wr5_ready", w_ready, 1'b1);
    chk("wr5_port", {sram_en, sram_wmode, sram_wmask}, 4'b1101);
    chk("wr5_addr", sram_addr, 5);
    chk("wr5_wdata", sram_wdata, {DATA_W{1'b1}});
    @(negedge clock);
    w_valid = 1'b0; r_req_valid = 1'b1; r_addr = 6'd5;
    #1;
    chk("rd5_ready", r_req_ready, 1'b1);
    @(negedge clock);
    r_req_valid = 1'b0;
    #1;
    chk("rd5_lat1", r_resp_valid, 1'b0);
    @(negedge clock);
    r_resp_ready = 1'b1;
    #1;
    chk("rd5_lat2", r_resp_valid, 1'b1);
    chk("rd5_data", r_resp_data, lane0_ones);
    @(negedge clock);
    r_resp_ready = 1'b0;
    #1;
    chk("rd5_done", r_resp_valid, 1'b0);

    // Fill addrs 1..3 with distinct data.
    for (int k = 1; k <= 3; k++) begin
      @(negedge clock);
      w_valid = 1'b1; w_addr = 6'(k); w_mask = 2'b11; w_data = dat[k];
      #1;
      chk("fill_ready", w_ready, 1'b1);
    end

    // Backpressure: only two reads outstanding while the consumer stalls.
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      w_valid = 1'b0; r_req_valid = 1'b1; r_addr = (k < 2) ? 6'(k + 1) : 6'd3;
      #1;
      chk("bp_ready", r_req_ready, k < 2);
    end
    chk("bp_hold_valid", r_resp_valid, 1'b1);
    chk("bp_hold_data", r_resp_data, dat[1]);
    @(negedge clock);
    r_resp_ready = 1'b1;
    #1;
    chk("bp_pop1", {r_resp_valid, r_req_ready}, 2'b11);
    chk("bp_pop1_data", r_resp_data, dat[1]);
    chk("bp_resume_addr", sram_addr, 3);
    @(negedge clock);
    r_req_valid = 1'b0;
    #1;
    chk("bp_pop2_valid", r_resp_valid, 1'b1);
    chk("bp_pop2_data", r_resp_data, dat[2]);
    @(negedge clock);
    #1;
    chk("bp_pop3_valid", r_resp_valid, 1'b1);
    chk("bp_pop3_data", r_resp_data, dat[3]);
    @(negedge clock);
    #1;
    chk("bp_empty", r_resp_valid, 1'b0);

    // Anti-starvation: reads win 4 cycles, write wins the 5th, counter restarts.
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      w_valid = 1'b1; w_addr = 6'd10; w_mask = 2'b11; w_data = dat[4];
      r_req_valid = 1'b1; r_addr = 6'd0;
      #1;
      chk("starve_w", w_ready, (i == 4) || (i == 9));
      chk("starve_r", r_req_ready, !((i == 4) || (i == 9)));
    end
    @(negedge clock);
    w_valid = 1'b0; r_req_valid = 1'b0;
    @(negedge clock);
    @(negedge clock);
    #1;
    chk("starve_drained", r_resp_valid, 1'b0);

    // Back-to-back reads with sustained throughput.
    for (int k = 1; k <= 3; k++) begin
      @(negedge clock);
      r_req_valid = 1'b1; r_addr = 6'(k);
      #1;
      chk("b2b_ready", r_req_ready, 1'b1);
    end
    chk("b2b_v1", r_resp_valid, 1'b1);
    chk("b2b_d1", r_resp_data, dat[1]);
    @(negedge clock);
    r_req_valid = 1'b0;
    #1;
    chk("b2b_v2", r_resp_valid, 1'b1);
    chk("b2b_d2", r_resp_data, dat[2]);
    @(negedge clock);
    #1;
    chk("b2b_v3", r_resp_valid, 1'b1);
    chk("b2b_d3", r_resp_data, dat[3]);
    @(negedge clock);
    #1;
    chk("b2b_empty", r_resp_valid, 1'b0);

    // Reset in RUN, then again partway through init.
    @(negedge clock);
    set_idle();
    reset_n = 1'b0;
    #1;
    check_reset_outs("rst_run");
    @(negedge clock);
    init_run(20);
    @(negedge clock);
    reset_n = 1'b0;
    #1;
    check_reset_outs("rst_init");
    @(negedge clock);
    init_run(DEPTH);
    @(negedge clock);
    #1;
    chk("reinit_done", init_done, 1'b1);

    // Reset with a read in flight and one in the FIFO: both discarded.
    @(negedge clock);
    r_req_valid = 1'b1; r_addr = 6'd1;
    #1;
    chk("out1_ready", r_req_ready, 1'b1);
    @(negedge clock);
    r_addr = 6'd2;
    #1;
    chk("out2_ready", r_req_ready, 1'b1);
    @(negedge clock);
    r_req_valid = 1'b0;
    reset_n = 1'b0;
    #1;
    check_reset_outs("rst_rd");
    @(negedge clock);
    init_run(DEPTH);
    @(negedge clock);
    #1;
    chk("no_stale_resp", r_resp_valid, 1'b0);
    chk("rd_done2", init_done, 1'b1);
    @(negedge clock);
    r_req_valid = 1'b1; r_addr = 6'd1; r_resp_ready = 1'b1;
    #1;
    chk("post_rd_ready", r_req_ready, 1'b1);
    @(negedge clock);
    r_req_valid = 1'b0;
    @(negedge clock);
    #1;
    chk("post_rd_valid", r_resp_valid, 1'b1);
    chk("post_rd_data", r_resp_data, 0);
    @(negedge clock);
    #1;
    chk("post_rd_empty", r_resp_valid, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
